// File: rtl/ysyx_23060332_exu_ctrl.sv
// Multi-cycle sequencer for the NPC core: fetch at pc, hold the word for the IDU,
// retire addi with a one-cycle rf_wen strobe, stop on ebreak, illegal inst or fetch timeout.
module ysyx_23060332_exu_ctrl #(
   parameter int unsigned       ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'h8000_0000),
   parameter int unsigned       TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              ifu_req,
   output logic [ADDR_W-1:0] ifu_addr,
   input  logic              ifu_rvalid,
   input  logic [31:0]       ifu_rdata,
   output logic [31:0]       inst,
   input  logic              dec_valid,
   input  logic              dec_ebreak,
   output logic              rf_wen,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       retire_cnt,
   output logic              halted,
   output logic              trap,
   output logic [1:0]        trap_cause
);

   localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_WB,
      S_HALT,
      S_TRAP
   } state_e;

   state_e            state_q,  state_d;
   logic [ADDR_W-1:0] pc_q,     pc_d;
   logic [31:0]       inst_q,   inst_d;
   logic [31:0]       retire_q, retire_d;
   logic [WAIT_W-1:0] wait_q,   wait_d;
   logic [1:0]        cause_q,  cause_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         inst_q   <= '0;
         retire_q <= '0;
         wait_q   <= '0;
         cause_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         retire_q <= retire_d;
         wait_q   <= wait_d;
         cause_q  <= cause_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      retire_d = retire_q;
      wait_d   = wait_q;
      cause_d  = cause_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            // A response arriving on the last allowed cycle still beats the timeout.
            if (ifu_rvalid) begin
               inst_d  = ifu_rdata;
               wait_d  = '0;
               state_d = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               cause_d = CAUSE_TIMEOUT;
               state_d = S_TRAP;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            if (dec_ebreak) begin
               state_d = S_HALT;
            end else if (dec_valid) begin
               state_d = S_WB;
            end else begin
               cause_d = CAUSE_ILLEGAL;
               state_d = S_TRAP;
            end
         end
         S_WB: begin
            pc_d     = pc_q + ADDR_W'(4);
            retire_d = retire_q + 32'd1;
            state_d  = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_IDLE;
      endcase
   end

   // Every output is a register or a decode of the state register.
   assign ifu_req    = (state_q == S_FETCH);
   assign ifu_addr   = pc_q;
   assign pc         = pc_q;
   assign inst       = inst_q;
   assign rf_wen     = (state_q == S_WB);
   assign retire_cnt = retire_q;
   assign halted     = (state_q == S_HALT);
   assign trap       = (state_q == S_TRAP);
   assign trap_cause = cause_q;

endmodule

// File: tb/tb_ysyx_23060332_exu_ctrl.sv
// Bench for ysyx_23060332_exu_ctrl: a memory/IDU model feeds programs and an
// instruction-level schedule predicts the per-cycle outputs.
module tb_ysyx_23060332_exu_ctrl;

   localparam int          TO     = 4;
   localparam logic [31:0] BASE_A = 32'h8000_0000;
   localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ADDI5  = 32'h0050_0093;

   logic clk = 1'b0;
   logic rst_n, start, ifu_rvalid, dec_valid, dec_ebreak;
   logic [31:0] ifu_rdata;

   logic        req_a, wen_a, halt_a, trap_a, req_b, wen_b, halt_b, trap_b;
   logic [31:0] addr_a, inst_a, pc_a, ret_a, addr_b, inst_b, pc_b, ret_b;
   logic [1:0]  cause_a, cause_b;

   logic        req_m, wen_m, halt_m, trap_m;
   logic [31:0] addr_m, inst_m, pc_m, ret_m;
   logic [1:0]  cause_m;

   int sel = 0;
   logic [31:0] base_cur = BASE_A;
   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] prog [16];
   int          dly  [16];
   int          plen;
   int          fidx, wcnt;

   typedef struct packed {
      logic        req;
      logic        wen;
      logic [31:0] pc;
      logic [31:0] ret;
      logic [31:0] inst;
      logic        halted;
      logic        trap;
      logic [1:0]  cause;
   } exp_t;
   exp_t expq[$];

   always #5 clk = ~clk;

   ysyx_23060332_exu_ctrl #(.ADDR_W(32), .RESET_PC(BASE_A), .TIMEOUT_CYC(TO)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .ifu_req(req_a), .ifu_addr(addr_a),
      .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .inst(inst_a), .dec_valid(dec_valid),
      .dec_ebreak(dec_ebreak), .rf_wen(wen_a), .pc(pc_a), .retire_cnt(ret_a),
      .halted(halt_a), .trap(trap_a), .trap_cause(cause_a));

   ysyx_23060332_exu_ctrl #(.ADDR_W(32), .RESET_PC(BASE_B), .TIMEOUT_CYC(TO)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .ifu_req(req_b), .ifu_addr(addr_b),
      .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .inst(inst_b), .dec_valid(dec_valid),
      .dec_ebreak(dec_ebreak), .rf_wen(wen_b), .pc(pc_b), .retire_cnt(ret_b),
      .halted(halt_b), .trap(trap_b), .trap_cause(cause_b));

   always_comb begin
      req_m   = (sel == 1) ? req_b   : req_a;
      wen_m   = (sel == 1) ? wen_b   : wen_a;
      halt_m  = (sel == 1) ? halt_b  : halt_a;
      trap_m  = (sel == 1) ? trap_b  : trap_a;
      addr_m  = (sel == 1) ? addr_b  : addr_a;
      inst_m  = (sel == 1) ? inst_b  : inst_a;
      pc_m    = (sel == 1) ? pc_b    : pc_a;
      ret_m   = (sel == 1) ? ret_b   : ret_a;
      cause_m = (sel == 1) ? cause_b : cause_a;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic is_addi(input logic [31:0] w);
      return (w[6:0] == 7'h13) && (w[14:12] == 3'b000);
   endfunction

   function automatic logic [31:0] rand_addi();
      logic [31:0] w;
      w = $urandom;
      w[6:0]   = 7'h13;
      w[14:12] = 3'b000;
      return w;
   endfunction

   function automatic logic [31:0] rand_illegal();
      logic [31:0] w;
      w = $urandom;
      while (is_addi(w) || w == EBREAK) w = $urandom;
      return w;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] idx;
      idx = (a - base_cur) >> 2;
      return (idx < 32'(plen)) ? prog[idx] : 32'h0;
   endfunction

   function automatic void push(input logic req, input logic wen, input logic [31:0] p,
                                input logic [31:0] r, input logic [31:0] i,
                                input logic h, input logic t, input logic [1:0] c);
      exp_t e;
      e.req = req; e.wen = wen; e.pc = p; e.ret = r; e.inst = i;
      e.halted = h; e.trap = t; e.cause = c;
      expq.push_back(e);
   endfunction

   // Instruction-level schedule: fetch takes delay+1 cycles, then decode, then writeback.
   task automatic build_schedule();
      logic [31:0] p, r, last;
      p = base_cur; r = 0; last = 0;
      expq.delete();
      for (int i = 0; i < plen; i++) begin
         if (dly[i] >= TO) begin
            for (int j = 0; j < TO; j++) push(1, 0, p, r, last, 0, 0, 0);
            repeat (4) push(0, 0, p, r, last, 0, 1, 2);
            return;
         end
         for (int j = 0; j <= dly[i]; j++) push(1, 0, p, r, last, 0, 0, 0);
         last = prog[i];
         push(0, 0, p, r, last, 0, 0, 0);
         if (last == EBREAK) begin
            repeat (4) push(0, 0, p, r, last, 1, 0, 0);
            return;
         end
         if (!is_addi(last)) begin
            repeat (4) push(0, 0, p, r, last, 0, 1, 1);
            return;
         end
         push(0, 1, p, r, last, 0, 0, 0);
         p = p + 32'd4;
         r = r + 32'd1;
      end
   endtask

   // Called at negedge: models IDU flags and the memory for the coming posedge.
   task automatic drive();
      dec_valid  = is_addi(inst_m);
      dec_ebreak = (inst_m == EBREAK);
      start      = 1'($urandom_range(0, 1));
      if (req_m) begin
         if (fidx < plen && dly[fidx] < TO && wcnt == dly[fidx]) begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = mem_word(addr_m);
            wcnt = 0;
            fidx++;
         end else begin
            ifu_rvalid = 1'b0;
            ifu_rdata  = $urandom;
            wcnt++;
         end
      end else begin
         ifu_rvalid = 1'($urandom_range(0, 1));
         ifu_rdata  = $urandom;
      end
   endtask

   task automatic check_reset(input string nm);
      check_eq({nm, ".req"},   64'(req_m),   0);
      check_eq({nm, ".wen"},   64'(wen_m),   0);
      check_eq({nm, ".pc"},    64'(pc_m),    64'(base_cur));
      check_eq({nm, ".ret"},   64'(ret_m),   0);
      check_eq({nm, ".inst"},  64'(inst_m),  0);
      check_eq({nm, ".halt"},  64'(halt_m),  0);
      check_eq({nm, ".trap"},  64'(trap_m),  0);
      check_eq({nm, ".cause"}, 64'(cause_m), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0; ifu_rvalid = 1'b0; dec_valid = 1'b0; dec_ebreak = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_prog(input int s, input string nm);
      exp_t e;
      sel = s;
      base_cur = (s == 1) ? BASE_B : BASE_A;
      do_reset();
      check_reset({nm, ".rst"});
      build_schedule();
      fidx = 0; wcnt = 0;
      start = 1'b1;
      ifu_rvalid = 1'b1;
      ifu_rdata = $urandom;
      @(negedge clk);
      for (int k = 0; k < expq.size(); k++) begin
         e = expq[k];
         check_eq($sformatf("%s.req@%0d", nm, k),   64'(req_m),   64'(e.req));
         check_eq($sformatf("%s.wen@%0d", nm, k),   64'(wen_m),   64'(e.wen));
         check_eq($sformatf("%s.pc@%0d", nm, k),    64'(pc_m),    64'(e.pc));
         check_eq($sformatf("%s.addr@%0d", nm, k),  64'(addr_m),  64'(e.pc));
         check_eq($sformatf("%s.ret@%0d", nm, k),   64'(ret_m),   64'(e.ret));
         check_eq($sformatf("%s.inst@%0d", nm, k),  64'(inst_m),  64'(e.inst));
         check_eq($sformatf("%s.halt@%0d", nm, k),  64'(halt_m),  64'(e.halted));
         check_eq($sformatf("%s.trap@%0d", nm, k),  64'(trap_m),  64'(e.trap));
         check_eq($sformatf("%s.cause@%0d", nm, k), 64'(cause_m), 64'(e.cause));
         drive();
         @(negedge clk);
      end
   endtask

   task automatic reset_mid_fetch();
      sel = 1; base_cur = BASE_B;
      plen = 2; prog[0] = ADDI5; prog[1] = EBREAK; dly[0] = 3; dly[1] = 0;
      do_reset();
      fidx = 0; wcnt = 0;
      start = 1'b1;
      @(negedge clk);
      drive();
      @(negedge clk);
      check_eq("mid.fetching", 64'(req_m), 1);
      #2 rst_n = 1'b0;
      #1 check_reset("mid.async");
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0; ifu_rvalid = 1'b1; ifu_rdata = ADDI5;
      repeat (3) begin
         @(negedge clk);
         check_reset("mid.idle");
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ifu_rvalid = 1'b0; ifu_rdata = '0;
      dec_valid = 1'b0; dec_ebreak = 1'b0; plen = 0;

      plen = 2; prog[0] = ADDI5; prog[1] = EBREAK; dly[0] = 0; dly[1] = 0;
      run_prog(0, "one_addi");

      plen = 4;
      for (int i = 0; i < 3; i++) begin prog[i] = rand_addi(); dly[i] = 0; end
      prog[3] = EBREAK; dly[3] = 0;
      run_prog(0, "three_addi");

      plen = 3;
      for (int i = 0; i < 2; i++) begin prog[i] = rand_addi(); dly[i] = 3; end
      prog[2] = EBREAK; dly[2] = 3;
      run_prog(0, "slow_mem");

      plen = 1; prog[0] = 32'h0000_0033; dly[0] = 1;
      run_prog(0, "illegal");

      plen = 2; prog[0] = ADDI5; prog[1] = EBREAK; dly[0] = 0; dly[1] = TO + 5;
      run_prog(0, "timeout");

      reset_mid_fetch();
      plen = 2; prog[0] = ADDI5; prog[1] = EBREAK; dly[0] = 2; dly[1] = 1;
      run_prog(1, "wrap");

      for (int t = 0; t < 20; t++) begin
         int kind;
         plen = $urandom_range(1, 6);
         for (int i = 0; i < plen - 1; i++) begin
            prog[i] = rand_addi();
            dly[i]  = $urandom_range(0, TO - 1);
         end
         kind = $urandom_range(0, 2);
         prog[plen-1] = (kind == 0) ? EBREAK : (kind == 1) ? rand_illegal() : rand_addi();
         dly[plen-1]  = (kind == 2) ? TO + $urandom_range(0, 3) : $urandom_range(0, TO - 1);
         run_prog($urandom_range(0, 1), $sformatf("rnd%0d", t));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
